// File: rtl/mips_cpu_bus_mem_model_if.sv
// Avalon-MM bus bundle between a CPU bus master and the memory model.
interface mips_cpu_bus_mem_model_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output read, write, addr, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  read, write, addr, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_bus_mem_model.sv
// Avalon-MM slave memory model with programmable wait states and sticky error flag.
// Optional MEM_RAND_WAIT_EN adds 0..3 LFSR-driven extra wait states per transfer.
module mips_cpu_bus_mem_model #(
  parameter string       RAM_FILE    = "",
  parameter int          DEPTH_WORDS = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter int          BIG_ENDIAN  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  mips_cpu_bus_mem_model_if.slave   bus,
  output logic                      err,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);

  localparam int          BYTE_AW   = (DEPTH_WORDS > 1) ? $clog2(4 * DEPTH_WORDS) : 2;
  localparam int          MEM_BYTES = 4 * DEPTH_WORDS;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 1..255");
    end
    if (DEPTH_WORDS < 1 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [8:0]           r_cnt;
  logic [8:0]           w_cnt_load;
  logic [31:0]          r_readdata;
  logic                 r_err;
  logic [31:0]          r_rd_count;
  logic [31:0]          r_wr_count;
  logic [7:0]           r_mem [0:MEM_BYTES-1];

  logic                 w_req;
  logic                 w_collide;
  logic                 w_bad;
  logic [31:0]          w_off;
  logic [BYTE_AW-1:0]   w_base;
  logic [31:0]          w_rdword;
  logic                 w_wait;
  logic                 w_enter_acc;
  logic                 w_accept;
  logic                 w_abort;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) r_mem[i] = 8'h00;
  end

  assign w_req     = bus.read | bus.write;
  assign w_collide = bus.read & bus.write;
  assign w_off     = bus.addr - BASE_ADDR;
  assign w_bad     = (bus.addr[1:0] != 2'b00) || ({1'b0, w_off} >= MEM_LIMIT);
  assign w_base    = w_off[BYTE_AW-1:0] & ~BYTE_AW'(3);

`ifdef MEM_RAND_WAIT_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_cnt_load = 9'(WAIT_CYCLES - 1) + {7'd0, r_lfsr[1:0]};
`else
  assign w_cnt_load = 9'(WAIT_CYCLES - 1);
`endif

  // Lane k is byte offset k; big-endian puts offset 0 in the top byte.
  always_comb begin
    w_rdword = '0;
    for (int k = 0; k < 4; k++) begin
      if (BIG_ENDIAN != 0) w_rdword[31-8*k -: 8] = r_mem[w_base | BYTE_AW'(k)];
      else                 w_rdword[8*k +: 8]    = r_mem[w_base | BYTE_AW'(k)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_state_nxt = (w_cnt_load == 9'd0) ? S_ACCEPT : S_WAIT;
      S_WAIT: begin
        if (!w_req)              w_state_nxt = S_IDLE;
        else if (r_cnt == 9'd1)  w_state_nxt = S_ACCEPT;
      end
      S_ACCEPT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wait      = !reset_n || (w_req && r_state != S_ACCEPT);
    w_enter_acc = (w_state_nxt == S_ACCEPT) && (r_state != S_ACCEPT);
    w_accept    = (r_state == S_ACCEPT) && w_req;
    w_abort     = (r_state == S_WAIT) && !w_req;
  end

  assign bus.waitrequest = w_wait;
  assign bus.readdata    = r_readdata;
  assign err             = r_err;
  assign rd_count        = r_rd_count;
  assign wr_count        = r_wr_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_readdata <= '0;
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) r_cnt <= w_cnt_load;
      else if (r_state == S_WAIT)     r_cnt <= r_cnt - 9'd1;
      if (w_enter_acc && bus.read && !bus.write) r_readdata <= w_bad ? 32'd0 : w_rdword;
      if (w_abort || (w_accept && (w_collide || w_bad))) r_err <= 1'b1;
      if (w_accept && !w_collide) begin
        if (bus.read) r_rd_count <= r_rd_count + 32'd1;
        else          r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  // Storage is deliberately outside reset so images survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_accept && bus.write && !bus.read && !w_bad) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.byteenable[k]) begin
          if (BIG_ENDIAN != 0) r_mem[w_base | BYTE_AW'(k)] <= bus.writedata[31-8*k -: 8];
          else                 r_mem[w_base | BYTE_AW'(k)] <= bus.writedata[8*k +: 8];
        end
      end
    end
  end

endmodule
